// File: rtl/operate_executor.sv
`default_nettype none
// ============================================================================
//  Module   : operate_executor
//  Purpose  : Executes PDP-8 operate (opcode 7) instructions. Accepts an
//             instruction and its PC over a valid/ready handshake, presents
//             the operate field plus the architectural AC/link to an external
//             combinational micro-instruction decoder, captures its results,
//             and returns the next PC. Group-2 OSR/HLT/CLA and the AND-form
//             skip are resolved here.
//  Ports    : clk, reset_n            clock, async active-low reset
//             op_valid/op_ready       instruction handshake from sequencer
//             op_word, op_pc          instruction word and its address
//             switch_reg, cont        front panel switches / continue pulse
//             i_reg, ac_reg, l_reg    operands driven to the decoder
//             ac_micro, l_micro, skip decoder results
//             micro_g1/g2/g3          decoder group flags
//             pc_next, pc_valid       next PC and its one-cycle strobe
//             halted, bad_op          HALT state / bad-instruction strobe
//  Revision : 1.0  initial release
// ============================================================================
module operate_executor #(
    parameter int WORD_W = 12,
    parameter int IR_W   = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [WORD_W-1:0] op_word,
    input  logic [WORD_W-1:0] op_pc,
    input  logic [WORD_W-1:0] switch_reg,
    input  logic              cont,
    output logic [IR_W-1:0]   i_reg,
    output logic [WORD_W-1:0] ac_reg,
    output logic              l_reg,
    input  logic [WORD_W-1:0] ac_micro,
    input  logic              l_micro,
    input  logic              skip,
    input  logic              micro_g1,
    input  logic              micro_g2,
    input  logic              micro_g3,
    output logic [WORD_W-1:0] pc_next,
    output logic              pc_valid,
    output logic              halted,
    output logic              bad_op
);

    // Operate-field bit positions used by the executor itself
    localparam int       c_BIT_CLA = 7;
    localparam int       c_BIT_SMA = 6;   // SPA in the AND form
    localparam int       c_BIT_SZA = 5;   // SNA in the AND form
    localparam int       c_BIT_SNL = 4;   // SZL in the AND form
    localparam int       c_BIT_AND = 3;
    localparam int       c_BIT_OSR = 2;
    localparam int       c_BIT_HLT = 1;
    localparam logic [2:0] c_OPC_OPR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_WB   = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [IR_W-1:0]   r_ir;
    logic [WORD_W-1:0] r_pc;
    logic              r_op_ok;
    logic [WORD_W-1:0] r_ac;
    logic              r_link;
    logic [WORD_W-1:0] r_pc_next;
    logic              r_hlt;
    logic              r_bad;

    logic              w_accept;
    logic              w_bad;
    logic              w_g1;
    logic              w_g2;
    logic              w_and_skip;
    logic              w_skip_taken;
    logic [WORD_W-1:0] w_g2_ac;
    logic [WORD_W-1:0] w_ac_new;
    logic              w_link_new;
    logic              w_hlt;
    logic [WORD_W-1:0] w_pc_inc;

    assign w_accept = op_valid && (r_state == ST_IDLE);

    // ------------------------------------------------------------------
    // State register and next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (op_valid) w_state_next = ST_EVAL;
            ST_EVAL: w_state_next = ST_WB;
            ST_WB:   w_state_next = r_hlt ? ST_HALT : ST_IDLE;
            ST_HALT: if (cont) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // EVAL-cycle result selection. A wrong opcode overrides whatever the
    // decoder reports, since it still decodes the low nine bits.
    // ------------------------------------------------------------------
    assign w_bad = !r_op_ok || micro_g3;
    assign w_g1  = !w_bad && micro_g1;
    assign w_g2  = !w_bad && micro_g2;

    // AND-form skip, evaluated on the pre-instruction AC/link
    assign w_and_skip = (!r_ir[c_BIT_SMA] || !r_ac[WORD_W-1])
                     && (!r_ir[c_BIT_SZA] || (r_ac != '0))
                     && (!r_ir[c_BIT_SNL] || !r_link);

    assign w_skip_taken = w_g2 && (r_ir[c_BIT_AND] ? w_and_skip : skip);

    assign w_g2_ac = (r_ir[c_BIT_CLA] ? '0 : r_ac)
                   | (r_ir[c_BIT_OSR] ? switch_reg : '0);

    assign w_ac_new   = w_g1 ? ac_micro : (w_g2 ? w_g2_ac : r_ac);
    assign w_link_new = w_g1 ? l_micro : r_link;
    assign w_hlt      = w_g2 && r_ir[c_BIT_HLT];
    assign w_pc_inc   = w_skip_taken ? WORD_W'(2) : WORD_W'(1);

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ir      <= '0;
            r_pc      <= '0;
            r_op_ok   <= 1'b0;
            r_ac      <= '0;
            r_link    <= 1'b0;
            r_pc_next <= '0;
            r_hlt     <= 1'b0;
            r_bad     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ir    <= op_word[IR_W-1:0];
                r_pc    <= op_pc;
                r_op_ok <= (op_word[WORD_W-1 -: 3] == c_OPC_OPR);
            end
            if (r_state == ST_EVAL) begin
                r_ac      <= w_ac_new;
                r_link    <= w_link_new;
                r_pc_next <= r_pc + w_pc_inc;   // wraps modulo 2^WORD_W
                r_hlt     <= w_hlt;
                r_bad     <= w_bad;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign op_ready = (r_state == ST_IDLE);
    assign pc_valid = (r_state == ST_WB);
    assign halted   = (r_state == ST_HALT);
    assign bad_op   = pc_valid && r_bad;
    assign i_reg    = r_ir;
    assign ac_reg   = r_ac;
    assign l_reg    = r_link;
    assign pc_next  = r_pc_next;

endmodule
`default_nettype wire

// File: tb/tb_operate_executor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operate_executor
//  Purpose  : Self-checking bench for operate_executor. Contains a
//             behavioural PDP-8 micro-instruction decoder feeding the DUT and
//             an instruction-level reference model of the operate class.
//  Revision : 1.0  initial release
// ============================================================================
module tb_operate_executor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        op_valid;
    logic        op_ready;
    logic [11:0] op_word;
    logic [11:0] op_pc;
    logic [11:0] switch_reg;
    logic        cont;
    logic [8:0]  i_reg;
    logic [11:0] ac_reg;
    logic        l_reg;
    logic [11:0] ac_micro;
    logic        l_micro;
    logic        skip;
    logic        micro_g1;
    logic        micro_g2;
    logic        micro_g3;
    logic [11:0] pc_next;
    logic        pc_valid;
    logic        halted;
    logic        bad_op;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        logic [11:0] pc;
        logic [11:0] ac;
        logic        l;
        logic        bad;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    logic [11:0] m_ac;
    logic        m_l;

    operate_executor #(.WORD_W(12), .IR_W(9)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_word    (op_word),
        .op_pc      (op_pc),
        .switch_reg (switch_reg),
        .cont       (cont),
        .i_reg      (i_reg),
        .ac_reg     (ac_reg),
        .l_reg      (l_reg),
        .ac_micro   (ac_micro),
        .l_micro    (l_micro),
        .skip       (skip),
        .micro_g1   (micro_g1),
        .micro_g2   (micro_g2),
        .micro_g3   (micro_g3),
        .pc_next    (pc_next),
        .pc_valid   (pc_valid),
        .halted     (halted),
        .bad_op     (bad_op)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Group-1 semantics on the 13-bit {link, AC}: clear, complement,
    // increment, then rotate/swap.
    function automatic logic [12:0] g1_apply(input logic [8:0] ir,
                                             input logic [11:0] ac,
                                             input logic l);
        logic [12:0] v;
        int          n;
        v = {l, ac};
        n = ir[1] ? 2 : 1;
        if (ir[7]) v[11:0] = 12'o0000;
        if (ir[6]) v[12]   = 1'b0;
        if (ir[5]) v[11:0] = ~v[11:0];
        if (ir[4]) v[12]   = ~v[12];
        if (ir[0]) v       = v + 13'd1;
        case ({ir[3], ir[2]})
            2'b10:   for (int k = 0; k < n; k++) v = {v[0], v[12:1]};
            2'b01:   for (int k = 0; k < n; k++) v = {v[11:0], v[12]};
            2'b00:   if (ir[1]) v = {v[12], v[5:0], v[11:6]};
            default: ;
        endcase
        return v;
    endfunction

    // External decoder model driven from the DUT's operand outputs
    logic [12:0] dec_v;
    always_comb begin
        dec_v    = g1_apply(i_reg, ac_reg, l_reg);
        micro_g1 = !i_reg[8];
        micro_g2 = i_reg[8] && !i_reg[0];
        micro_g3 = i_reg[8] && i_reg[0];
        ac_micro = micro_g1 ? dec_v[11:0] : ac_reg;
        l_micro  = micro_g1 ? dec_v[12] : l_reg;
        skip     = micro_g2 && ((i_reg[6] && ac_reg[11]) ||
                                (i_reg[5] && (ac_reg == 12'o0000)) ||
                                (i_reg[4] && l_reg));
    end

    // Instruction-level reference model of one operate instruction
    function automatic void model_exec(input logic [11:0] w, input logic [11:0] pc,
                                       input logic [11:0] ac, input logic l,
                                       input logic [11:0] sr,
                                       output logic [11:0] nac, output logic nl,
                                       output logic [11:0] npc, output logic hlt,
                                       output logic bad);
        logic [8:0]  ir;
        logic [12:0] v;
        logic        orf;
        logic        skp;
        ir  = w[8:0];
        nac = ac;
        nl  = l;
        hlt = 1'b0;
        bad = 1'b0;
        skp = 1'b0;
        if (w[11:9] != 3'b111 || (ir[8] && ir[0])) begin
            bad = 1'b1;
        end else if (!ir[8]) begin
            v   = g1_apply(ir, ac, l);
            nac = v[11:0];
            nl  = v[12];
        end else begin
            orf = (ir[6] && ac[11]) || (ir[5] && ac == 12'o0000) || (ir[4] && l);
            skp = ir[3] ? !orf : orf;
            nac = (ir[7] ? 12'o0000 : ac) | (ir[2] ? sr : 12'o0000);
            hlt = ir[1];
        end
        npc = pc + (skp ? 12'd2 : 12'd1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0o, expected %0o (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: every pc_valid strobe is matched against the model
    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b1) begin
            if (pc_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pc_valid", {31'd0, pc_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pc_next", pc_next, e.pc);
                    chk("ac_reg",  ac_reg,  e.ac);
                    chk("l_reg",   l_reg,   e.l);
                    chk("bad_op",  bad_op,  e.bad);
                    chk("latency", cyc,     e.cyc);
                end
            end else if (bad_op) begin
                chk("bad_op_without_pc_valid", {31'd0, bad_op}, 32'd0);
            end
        end
    end

    task automatic do_op(input logic [11:0] w, input logic [11:0] pc, input logic [11:0] sr);
        exp_t        e;
        logic [11:0] nac;
        logic [11:0] npc;
        logic        nl;
        logic        hlt;
        logic        bad;
        logic        found;
        model_exec(w, pc, m_ac, m_l, sr, nac, nl, npc, hlt, bad);
        @(posedge clk);
        #1;
        op_word    = w;
        op_pc      = pc;
        switch_reg = sr;
        op_valid   = 1'b1;
        found      = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (op_ready) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            chk("accept_timeout", 32'd0, 32'd1);
            op_valid = 1'b0;
            return;
        end
        e.pc  = npc;
        e.ac  = nac;
        e.l   = nl;
        e.bad = bad;
        e.cyc = cyc + 2;
        exp_q.push_back(e);
        m_ac = nac;
        m_l  = nl;
        @(posedge clk);
        #1 op_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("halted_after_op", halted, hlt);
    endtask

    task automatic release_halt();
        @(posedge clk);
        #1 cont = 1'b1;
        @(posedge clk);
        #1 cont = 1'b0;
        @(negedge clk);
        chk("halted_after_cont", halted, 1'b0);
        chk("op_ready_after_cont", op_ready, 1'b1);
    endtask

    initial begin
        reset_n    = 1'b0;
        op_valid   = 1'b0;
        op_word    = 12'o0000;
        op_pc      = 12'o0000;
        switch_reg = 12'o0000;
        cont       = 1'b0;
        m_ac       = 12'o0000;
        m_l        = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ac",       ac_reg,   12'o0000);
        chk("rst_l",        l_reg,    1'b0);
        chk("rst_i_reg",    i_reg,    9'o000);
        chk("rst_pc_next",  pc_next,  12'o0000);
        chk("rst_op_ready", op_ready, 1'b1);
        chk("rst_pc_valid", pc_valid, 1'b0);
        chk("rst_halted",   halted,   1'b0);
        chk("rst_bad_op",   bad_op,   1'b0);

        // CLA CMA
        do_op(12'o7240, 12'o0100, 12'o0000);
        chk("lit_cla_cma_ac", ac_reg, 12'o7777);
        chk("lit_cla_cma_pc", pc_next, 12'o0101);

        // Reset while the next instruction is in EVAL
        @(posedge clk);
        #1;
        op_word  = 12'o7001;
        op_pc    = 12'o0101;
        op_valid = 1'b1;
        @(negedge clk);
        chk("mid_accept_ready", op_ready, 1'b1);
        @(posedge clk);
        #1 op_valid = 1'b0;
        @(negedge clk);
        chk("mid_eval_ready", op_ready, 1'b0);
        reset_n = 1'b0;
        m_ac    = 12'o0000;
        m_l     = 1'b0;
        #1;
        chk("mid_rst_ac",    ac_reg,   12'o0000);
        chk("mid_rst_l",     l_reg,    1'b0);
        chk("mid_rst_ready", op_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_rst_no_pc_valid", pc_valid, 1'b0);
        end

        // IAC carry into link, then RAL
        do_op(12'o7240, 12'o0100, 12'o0000);
        do_op(12'o7001, 12'o0101, 12'o0000);
        chk("lit_iac_ac", ac_reg, 12'o0000);
        chk("lit_iac_l",  l_reg,  1'b1);
        do_op(12'o7004, 12'o0102, 12'o0000);
        chk("lit_ral_ac", ac_reg, 12'o0001);
        chk("lit_ral_l",  l_reg,  1'b0);

        // Skips
        do_op(12'o7604, 12'o0103, 12'o4000);
        do_op(12'o7500, 12'o0200, 12'o4000);
        chk("lit_sma_pc", pc_next, 12'o0202);
        do_op(12'o7200, 12'o0201, 12'o0000);
        do_op(12'o7510, 12'o0200, 12'o0000);
        chk("lit_spa_pc", pc_next, 12'o0202);
        do_op(12'o7410, 12'o7777, 12'o0000);
        chk("lit_skp_wrap", pc_next, 12'o0001);

        // OSR with link preserved
        do_op(12'o7020, 12'o0300, 12'o0000);
        do_op(12'o7604, 12'o0301, 12'o1234);
        do_op(12'o7604, 12'o0302, 12'o5555);
        chk("lit_osr_ac", ac_reg, 12'o5555);
        chk("lit_osr_l",  l_reg,  1'b1);
        chk("lit_osr_pc", pc_next, 12'o0303);

        // More sense combinations and group-1 rotates (model-checked)
        do_op(12'o7440, 12'o0310, 12'o0000);   // SZA, AC!=0: no skip
        do_op(12'o7450, 12'o0311, 12'o0000);   // SNA: skip
        do_op(12'o7430, 12'o0312, 12'o0000);   // SZL, L=1: no skip
        do_op(12'o7420, 12'o0313, 12'o0000);   // SNL: skip
        do_op(12'o7010, 12'o0314, 12'o0000);   // RAR
        do_op(12'o7012, 12'o0315, 12'o0000);   // RTR
        do_op(12'o7006, 12'o0316, 12'o0000);   // RTL
        do_op(12'o7002, 12'o0317, 12'o0000);   // BSW
        do_op(12'o7041, 12'o0320, 12'o0000);   // CIA

        // HLT: nothing accepted while halted, cont releases
        do_op(12'o7402, 12'o0400, 12'o0000);
        chk("lit_hlt_pc", pc_next, 12'o0401);
        @(posedge clk);
        #1;
        op_word  = 12'o7001;
        op_pc    = 12'o0401;
        op_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("halt_op_ready", op_ready, 1'b0);
            chk("halt_halted",   halted,   1'b1);
        end
        @(posedge clk);
        #1 op_valid = 1'b0;
        release_halt();

        // cont outside HALT is ignored
        release_halt();

        // Group 3 and wrong opcode are NOPs flagged by bad_op
        do_op(12'o7401, 12'o0500, 12'o0000);
        chk("lit_g3_pc", pc_next, 12'o0501);
        do_op(12'o1234, 12'o0501, 12'o0000);

        // HLT with skip, wrapping 7776+2 to 0000
        do_op(12'o7412, 12'o7776, 12'o0000);
        chk("lit_hlt_skip_pc", pc_next, 12'o0000);
        release_halt();

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/operate_executor.md
Name: operate_executor

Overview:
- Executes PDP-8 operate (opcode 7) instructions.
- Accepts an instruction and its PC from the fetch/sequencer over a valid/ready handshake, and drives the combinational micro-instruction decoder.
- Captures the decoder's AC/link/skip/group results, and owns the architectural AC and link registers.
- Returns the next PC to the sequencer; implements group-2 OSR/HLT/CLA itself.

Parameters:
- WORD_W, 12, PDP-8 word width (AC, PC, switch register).
- IR_W, 9, operate-field width driven to the decoder (instruction bits 8:0).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- op_valid  in  1  instruction offered by sequencer
- op_ready  out  1  executor can accept an instruction
- op_word  in  WORD_W  full instruction; bits 11:9 must be 3'b111
- op_pc  in  WORD_W  address of this instruction
- switch_reg  in  WORD_W  front-panel switches for OSR
- cont  in  1  one-cycle pulse that releases HALT
- i_reg  out  IR_W  to decoder
- ac_reg  out  WORD_W  to decoder; equals architectural AC
- l_reg  out  1  to decoder; equals architectural link
- ac_micro  in  WORD_W  from decoder
- l_micro  in  1  from decoder
- skip  in  1  from decoder (group-2 OR result)
- micro_g1, micro_g2, micro_g3  in  1 each  decoder group flags
- pc_next  out  WORD_W  next PC to sequencer
- pc_valid  out  1  one-cycle strobe qualifying pc_next
- halted  out  1  executor in HALT
- bad_op  out  1  one-cycle strobe: op_word[11:9] != 7, or group-3 instruction (treated as NOP)

Behaviour:
- Reset (async, reset_n=0):
  - State=IDLE; AC=0; link=0; i_reg=0; pc_next=0.
  - pc_valid=0, halted=0, bad_op=0, op_ready=1.
  - Reset mid-operation discards the in-flight instruction; no pc_valid is issued.
- States: IDLE, EVAL, WB, HALT.
- IDLE:
  - op_ready=1.
  - On op_valid&op_ready, register op_word[8:0] into i_reg and op_pc into a PC latch; go to EVAL.
- EVAL (one cycle, op_ready=0): decoder outputs settle from i_reg/ac_reg/l_reg; the executor samples them at the end of the cycle.
  - micro_g1: new AC=ac_micro, new link=l_micro.
  - micro_g2:
    - Skip condition = skip for the OR form (i_reg[3]=0); for the AND form (i_reg[3]=1) the executor computes it from the pre-instruction AC/link as (!SPA|!AC[11]) & (!SNA|AC!=0) & (!SZL|!link). With no sense bits set, the AND form always skips (SKP).
    - Skip is always evaluated on the pre-instruction AC/link.
    - Then AC=(i_reg[7]?0:AC)|(i_reg[2]?switch_reg:0); link unchanged; HLT=i_reg[1].
  - micro_g3 or bad opcode: AC/link unchanged; bad_op=1 for one cycle.
  - Go to WB.
- WB (one cycle):
  - AC/link registers update at entry to WB, visible on ac_reg/l_reg in WB.
  - pc_next = PC latch + 1, or + 2 when skip taken, modulo 2^WORD_W (7777 wraps to 0000, 7776+2 → 0000, 7777+2 → 0001).
  - pc_valid=1 for exactly this cycle.
  - If HLT, go to HALT; else go to IDLE.
- Latency: handshake in cycle N → pc_valid in cycle N+2; maximum throughput one instruction per 3 cycles.
- HALT:
  - halted=1, op_ready=0; AC/link held.
  - cont=1 → IDLE (halted deasserts the next cycle).
  - cont outside HALT is ignored.
- Simultaneous events:
  - op_valid during EVAL/WB/HALT is not accepted; the sequencer holds op_word/op_pc stable until op_ready.
  - HLT with skip: the skip is still applied to pc_next before halting.
- i_reg holds its value outside IDLE→EVAL; the decoder sees a stable input for the entire EVAL cycle.

Test Plan:
- Reset with AC preloaded via prior ops, reset_n low mid-EVAL → AC=0, link=0, op_ready=1, no pc_valid.
- AC=0, L=0, op 7240 (CLA CMA) at pc 0100 → AC=7777, L=0, pc_next=0101 at N+2.
- AC=7777, L=0, op 7001 (IAC) → AC=0000, L=1. Then op 7004 (RAL) → AC=0001, L=0.
- AC=4000, op 7500 (SMA) at pc 0200 → pc_next=0202. Same with AC=0000 and 7510 (SPA) → 0202. Op 7410 (SKP) at pc 7777 → pc_next=0001.
- AC=1234, switch_reg=5555, op 7604 (CLA OSR) → AC=5555, link unchanged, pc_next=pc+1.
- Op 7402 (HLT) → pc_valid with pc+1, then halted=1, op_ready=0 with op_valid asserted for 10 cycles and nothing accepted; cont pulse → halted=0, op_ready=1. Op 7401 (group 3) → bad_op pulse, AC unchanged, pc+1.
